// File: rtl/fst_mon_pkg.sv
// Shared types and width helpers for the fst run-control monitor.
package fst_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    HALT = 2'd1,
    WDT  = 2'd2
  } fault_cause_t;

  // Index width for a trace of the given depth (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Stall counter width able to hold WDT_CYCLES-1.
  function automatic int stall_w(input int wdt_cycles);
    return $clog2(wdt_cycles) + 1;
  endfunction

endpackage

// File: rtl/fst_trace_buf.sv
// Circular PC trace: DEPTH entries, newest at index 0, registered
// read-before-write port that returns 0 for indices beyond the fill level.
module fst_trace_buf
  import fst_mon_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 8,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [PC_W-1:0]  i_wdata,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [PC_W-1:0]  o_rd_data,
  output logic [IDX_W:0]   o_count
);

  logic [PC_W-1:0]  r_mem [DEPTH];
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W:0]   r_count;
  logic [PC_W-1:0]  r_rd_data;

  logic [IDX_W-1:0] w_rd_addr;
  logic             w_rd_hit;

  // DEPTH is a power of two, so plain wrap-around gives the modulo.
  assign w_rd_addr = r_wr_ptr - IDX_W'(1) - i_rd_idx;
  assign w_rd_hit  = ({1'b0, i_rd_idx} < r_count);

  // Storage is deliberately not cleared; the fill level masks stale entries.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Write pointer and fill level, saturating at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_we) begin
      r_wr_ptr <= r_wr_ptr + IDX_W'(1);
      if (r_count != (IDX_W+1)'(DEPTH)) r_count <= r_count + (IDX_W+1)'(1);
    end
  end

  // Registered read using the pointer/count as they were before this edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_data <= '0;
    else          r_rd_data <= w_rd_hit ? r_mem[w_rd_addr] : '0;
  end

  assign o_rd_data = r_rd_data;
  assign o_count   = r_count;

endmodule

// File: rtl/fst_run_monitor.sv
// Run-control monitor beside the fst core: flags halts and PC stalls,
// counts RUN cycles and keeps a trace of recent distinct PCs.
//
// state  | meaning
// IDLE   | waiting for the first valid PC after reset/clear
// RUN    | core running; cycle counter and watchdog active
// HALTED | legal stop (ALLOW_HALT=1); everything frozen
// FAULT  | illegal halt or watchdog expiry; everything frozen
module fst_run_monitor
  import fst_mon_pkg::*;
#(
  parameter int PC_W       = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32,
  parameter int WDT_CYCLES = 1024,
  parameter int ALLOW_HALT = 0,
  localparam int IDX_W = idx_w(DEPTH),
  localparam int SW    = stall_w(WDT_CYCLES)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_valid_in,
  input  logic             halting_in,
  input  logic             clear_in,
  input  logic [IDX_W-1:0] rd_idx_in,
  output logic [PC_W-1:0]  rd_pc_out,
  output logic [IDX_W:0]   trace_count_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic [1:0]       state_out,
  output logic [1:0]       fault_cause_out,
  output logic             fault_out
);

  mon_state_t   r_state;
  fault_cause_t r_cause;
  logic         r_fault;
  logic [CNT_W-1:0] r_cyc;
  logic [SW-1:0]    r_stall;
  logic [PC_W-1:0]  r_last_pc;

  logic w_stall;
  logic w_wdt_hit;
  logic w_we;

  assign w_stall   = !pc_valid_in || (pc_in == r_last_pc);
  assign w_wdt_hit = w_stall && (r_stall == SW'(WDT_CYCLES - 1));

  // Trace writes only on a fresh PC; halts and stalls never write.
  assign w_we = !clear_in && pc_valid_in &&
                ((r_state == IDLE) ||
                 ((r_state == RUN) && !halting_in && (pc_in != r_last_pc)));

  // Run-control FSM with cycle counter and stall watchdog.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state   <= IDLE;
      r_cause   <= NONE;
      r_fault   <= 1'b0;
      r_cyc     <= '0;
      r_stall   <= '0;
      r_last_pc <= '0;
    end else if (clear_in) begin
      r_state <= IDLE;
      r_cause <= NONE;
      r_fault <= 1'b0;
      r_cyc   <= '0;
      r_stall <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pc_valid_in) begin
            r_state   <= RUN;
            r_last_pc <= pc_in;
          end
        end
        RUN: begin
          if (r_cyc != '1) r_cyc <= r_cyc + CNT_W'(1);
          if (halting_in) begin
            if (ALLOW_HALT != 0) begin
              r_state <= HALTED;
            end else begin
              r_state <= FAULT;
              r_cause <= HALT;
              r_fault <= 1'b1;
            end
          end else if (w_stall) begin
            if (w_wdt_hit) begin
              r_state <= FAULT;
              r_cause <= WDT;
              r_fault <= 1'b1;
            end else begin
              r_stall <= r_stall + SW'(1);
            end
          end else begin
            r_stall   <= '0;
            r_last_pc <= pc_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  fst_trace_buf #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_trace (
    .i_clk     (clk_in),
    .i_rst_n   (reset_n_in),
    .i_clr     (clear_in),
    .i_we      (w_we),
    .i_wdata   (pc_in),
    .i_rd_idx  (rd_idx_in),
    .o_rd_data (rd_pc_out),
    .o_count   (trace_count_out)
  );

  assign state_out       = r_state;
  assign fault_cause_out = r_cause;
  assign fault_out       = r_fault;
  assign cycle_cnt_out   = r_cyc;

endmodule

// File: tb/tb_fst_run_monitor.sv
// Directed bench for fst_run_monitor: DEPTH=8, WDT_CYCLES=16, CNT_W=8,
// one instance per halt policy driven by the same stimulus.
module tb_fst_run_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        valid, halting, clr;
  logic [2:0]  idx;

  logic [15:0] rd0, rd1;
  logic [3:0]  tc0, tc1;
  logic [7:0]  cyc0, cyc1;
  logic [1:0]  st0, st1, cause0, cause1;
  logic        flt0, flt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fst_run_monitor #(.PC_W(16), .DEPTH(8), .CNT_W(8), .WDT_CYCLES(16), .ALLOW_HALT(0)) dut0 (
    .clk_in(clk), .reset_n_in(rst_n), .pc_in(pc), .pc_valid_in(valid),
    .halting_in(halting), .clear_in(clr), .rd_idx_in(idx),
    .rd_pc_out(rd0), .trace_count_out(tc0), .cycle_cnt_out(cyc0),
    .state_out(st0), .fault_cause_out(cause0), .fault_out(flt0));

  fst_run_monitor #(.PC_W(16), .DEPTH(8), .CNT_W(8), .WDT_CYCLES(16), .ALLOW_HALT(1)) dut1 (
    .clk_in(clk), .reset_n_in(rst_n), .pc_in(pc), .pc_valid_in(valid),
    .halting_in(halting), .clear_in(clr), .rd_idx_in(idx),
    .rd_pc_out(rd1), .trace_count_out(tc1), .cycle_cnt_out(cyc1),
    .state_out(st1), .fault_cause_out(cause1), .fault_out(flt1));

  typedef struct {
    logic        v;
    logic [15:0] pc;
    logic        clr;
    logic [2:0]  idx;
    logic [1:0]  st;
    logic [3:0]  tc;
    logic [7:0]  cyc;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_rd"},    32'(rd0),    32'd0);
    chk({tag, "_tc"},    32'(tc0),    32'd0);
    chk({tag, "_cyc"},   32'(cyc0),   32'd0);
    chk({tag, "_st"},    32'(st0),    32'd0);
    chk({tag, "_cause"}, 32'(cause0), 32'd0);
    chk({tag, "_flt"},   32'(flt0),   32'd0);
  endtask

  initial begin
    //            v  pc      clr idx   st    tc    cyc    rd
    vecs[0]  = '{1'b1, 16'h0000, 1'b0, 3'd0, 2'd1, 4'd1, 8'd0,  16'h0000};
    vecs[1]  = '{1'b1, 16'h0001, 1'b0, 3'd0, 2'd1, 4'd2, 8'd1,  16'h0000};
    vecs[2]  = '{1'b1, 16'h0002, 1'b0, 3'd0, 2'd1, 4'd3, 8'd2,  16'h0001};
    vecs[3]  = '{1'b1, 16'h0003, 1'b0, 3'd1, 2'd1, 4'd4, 8'd3,  16'h0001};
    vecs[4]  = '{1'b1, 16'h0004, 1'b0, 3'd0, 2'd1, 4'd5, 8'd4,  16'h0003};
    vecs[5]  = '{1'b1, 16'h0005, 1'b0, 3'd0, 2'd1, 4'd6, 8'd5,  16'h0004};
    vecs[6]  = '{1'b1, 16'h0006, 1'b0, 3'd0, 2'd1, 4'd7, 8'd6,  16'h0005};
    vecs[7]  = '{1'b1, 16'h0007, 1'b0, 3'd0, 2'd1, 4'd8, 8'd7,  16'h0006};
    vecs[8]  = '{1'b1, 16'h0008, 1'b0, 3'd0, 2'd1, 4'd8, 8'd8,  16'h0007};
    vecs[9]  = '{1'b1, 16'h0009, 1'b0, 3'd0, 2'd1, 4'd8, 8'd9,  16'h0008};
    vecs[10] = '{1'b1, 16'h000A, 1'b0, 3'd0, 2'd1, 4'd8, 8'd10, 16'h0009};
    vecs[11] = '{1'b1, 16'h000B, 1'b0, 3'd0, 2'd1, 4'd8, 8'd11, 16'h000A};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 3'd0, 2'd1, 4'd8, 8'd12, 16'h000B};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 3'd7, 2'd1, 4'd8, 8'd13, 16'h0004};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 3'd3, 2'd1, 4'd8, 8'd14, 16'h0008};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 3'd0, 2'd0, 4'd0, 8'd0,  16'h000B};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 3'd0, 2'd0, 4'd0, 8'd0,  16'h0000};

    rst_n = 1'b0; pc = '0; valid = 1'b0; halting = 1'b0; clr = 1'b0; idx = '0;
    tick(); tick();
    chk_zero0("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk_zero0("idle20");

    // Fill, wrap and read the trace.
    for (int i = 0; i < 17; i++) begin
      valid = vecs[i].v; pc = vecs[i].pc; clr = vecs[i].clr; idx = vecs[i].idx;
      tick();
      chk($sformatf("v%0d_st", i),  32'(st0),  32'(vecs[i].st));
      chk($sformatf("v%0d_tc", i),  32'(tc0),  32'(vecs[i].tc));
      chk($sformatf("v%0d_cyc", i), 32'(cyc0), 32'(vecs[i].cyc));
      chk($sformatf("v%0d_rd", i),  32'(rd0),  32'(vecs[i].rd));
    end
    clr = 1'b0; idx = 3'd0;

    // Watchdog: 16 consecutive stall cycles on a held PC.
    valid = 1'b1; pc = 16'h0041; tick();
    pc = 16'h0042; tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) begin
        chk("wdt_pre_flt", 32'(flt0), 32'd0);
        chk("wdt_pre_st",  32'(st0),  32'd1);
      end
    end
    chk("wdt_flt",   32'(flt0),   32'd1);
    chk("wdt_cause", 32'(cause0), 32'd2);
    chk("wdt_st",    32'(st0),    32'd3);
    chk("wdt_cyc",   32'(cyc0),   32'd17);
    for (int i = 0; i < 5; i++) begin
      pc = 16'h0100 + 16'(i);
      tick();
    end
    chk("wdt_cyc_frozen", 32'(cyc0), 32'd17);
    chk("wdt_st_sticky",  32'(st0),  32'd3);
    chk("wdt_tc_frozen",  32'(tc0),  32'd2);
    chk("wdt_rd_frozen",  32'(rd0),  32'h42);

    // Halt policy on both instances.
    valid = 1'b0; clr = 1'b1; tick();
    chk("clr_st0", 32'(st0), 32'd0);
    chk("clr_st1", 32'(st1), 32'd0);
    clr = 1'b0;
    valid = 1'b1; pc = 16'h0001; tick();
    pc = 16'h0002; tick();
    pc = 16'h0003; halting = 1'b1; tick();
    halting = 1'b0; valid = 1'b0;
    chk("halt0_st",    32'(st0),    32'd3);
    chk("halt0_cause", 32'(cause0), 32'd1);
    chk("halt0_flt",   32'(flt0),   32'd1);
    chk("halt0_tc",    32'(tc0),    32'd2);
    chk("halt1_st",    32'(st1),    32'd2);
    chk("halt1_flt",   32'(flt1),   32'd0);
    chk("halt1_cause", 32'(cause1), 32'd0);
    chk("halt1_tc",    32'(tc1),    32'd2);
    tick(); tick();
    chk("halt0_sticky", 32'(st0),  32'd3);
    chk("halt1_sticky", 32'(st1),  32'd2);
    chk("halt1_cyc",    32'(cyc1), 32'd2);

    // clear_in outranks halting_in, both from a sticky state and from RUN.
    clr = 1'b1; halting = 1'b1; tick();
    chk("clrhalt_st0", 32'(st0), 32'd0);
    chk("clrhalt_st1", 32'(st1), 32'd0);
    clr = 1'b0; halting = 1'b0;
    valid = 1'b1; pc = 16'h0005; tick();
    chk("run_again_st", 32'(st0), 32'd1);
    clr = 1'b1; halting = 1'b1; tick();
    chk("clrhalt_run_st",  32'(st0),  32'd0);
    chk("clrhalt_run_flt", 32'(flt0), 32'd0);
    clr = 1'b0; halting = 1'b0;

    // Cycle counter saturation over 300 RUN-bound cycles.
    for (int i = 0; i < 300; i++) begin
      valid = 1'b1; pc = 16'h0200 + 16'(i);
      tick();
    end
    chk("sat_cyc", 32'(cyc0), 32'd255);
    chk("sat_st",  32'(st0),  32'd1);
    valid = 1'b0; clr = 1'b1; tick();
    chk("sat_clr_cyc", 32'(cyc0), 32'd0);
    clr = 1'b0;

    // Asynchronous reset between edges.
    valid = 1'b1;
    pc = 16'h0010; tick();
    pc = 16'h0011; tick();
    pc = 16'h0012; tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero0("async");
    chk("async_st1", 32'(st1), 32'd0);
    #1;
    rst_n = 1'b1;
    valid = 1'b0;
    tick();
    chk("post_rst_st", 32'(st0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fst_run_monitor.md
Name: fst_run_monitor

Overview:
- Synthesizable run-control monitor that sits beside the fst core, on the same clock and reset.
- Takes over in hardware the checks our simulation bench does today: the core must not halt after reset release, and the PC must keep advancing.
- Adds a cycle counter, a PC watchdog, and a circular trace of the last DEPTH PC values, readable by index for on-board debug (e.g. shown on the 7-seg display).
- Parametrised in PC width, trace depth, counter width, watchdog timeout, and halt policy.

Parameters:
- PC_W, 16, width of the PC and of trace entries.
- DEPTH, 8, number of trace entries; must be a power of 2 and at least 2.
- CNT_W, 32, width of the cycle counter.
- WDT_CYCLES, 1024, number of consecutive stall cycles that triggers a watchdog fault; must be at least 2.
- ALLOW_HALT, 0, halt policy: 1 means halting_in is a legal stop (state HALTED); 0 means halting_in is a fault (state FAULT).

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- reset_n_in  in  1  asynchronous, active-low reset.
- pc_in  in  PC_W  current core PC.
- pc_valid_in  in  1  pc_in is valid this cycle (core retired/fetched).
- halting_in  in  1  core halt indication.
- clear_in  in  1  synchronous clear of the monitor back to IDLE.
- rd_idx_in  in  $clog2(DEPTH)  trace read index; 0 = most recent entry.
- rd_pc_out  out  PC_W  registered trace read data.
- trace_count_out  out  $clog2(DEPTH)+1  number of valid trace entries.
- cycle_cnt_out  out  CNT_W  number of cycles spent in RUN.
- state_out  out  2  0 IDLE, 1 RUN, 2 HALTED, 3 FAULT.
- fault_cause_out  out  2  0 none, 1 illegal halt, 2 watchdog.
- fault_out  out  1  high exactly when state is FAULT.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; write pointer, stall counter and last-PC register all 0.
- Event priority within a cycle: clear_in > halting_in > watchdog > trace write.
- clear_in, in any state: next state IDLE. It clears the cycle counter, trace count, write pointer, stall counter and fault cause. Trace RAM contents are not cleared, but reads of index >= count return 0.
- IDLE: on pc_valid_in, go to RUN. The PC is written as trace entry 0 and last_pc is loaded. halting_in is ignored in IDLE.
- RUN:
  - cycle_cnt increments on every edge while in RUN and saturates at all-ones.
  - halting_in high: go to HALTED if ALLOW_HALT=1; otherwise go to FAULT with cause 1. No trace write on that cycle.
  - Stall cycle: pc_valid_in low, or pc_in equal to last_pc.
  - A stall cycle with stall_cnt == WDT_CYCLES-1 enters FAULT with cause 2. Any other stall cycle increments stall_cnt.
  - A valid, differing PC resets stall_cnt to 0, loads last_pc, and writes the trace.
  - Repeated identical PCs are not written to the trace.
- HALTED and FAULT are sticky: counters are frozen, the trace is frozen and readable, and only clear_in or reset leaves them.
- Trace buffer:
  - Each write stores at wr_ptr; wr_ptr then increments modulo DEPTH, wrapping and overwriting the oldest entry.
  - trace_count increments and saturates at DEPTH.
  - Read address = (wr_ptr - 1 - rd_idx_in) mod DEPTH.
  - rd_pc_out is registered, with 1-cycle latency from rd_idx_in. It is 0 if rd_idx_in >= trace_count.
  - A read and a write in the same cycle return the pre-write mapping (read-before-write).
- Reset asserted mid-run takes effect immediately, without waiting for a clock edge.

Decomposition:
- Package fst_mon_pkg holds:
  - mon_state_t enum: IDLE, RUN, HALTED, FAULT.
  - fault_cause_t enum: NONE, HALT, WDT.
  - localparam helpers for the index width.
- One sub-module, fst_trace_buf (parameters PC_W, DEPTH): owns wr_ptr, count, storage and the registered read port. Ports are a write enable/data pair plus the read index.
- The FSM, counters and watchdog stay in fst_run_monitor.

Test Plan (DEPTH=8, WDT_CYCLES=16, CNT_W=8 unless noted):
- Reset, then idle with pc_valid_in low for 20 cycles -> state_out=0, cycle_cnt_out=0, fault_out=0, trace_count_out=0.
- Valid PCs 0x0000..0x000B on consecutive cycles -> trace_count_out=8; rd_idx 0 gives 0x000B and rd_idx 7 gives 0x0004, one cycle after the index is applied; cycle_cnt_out=11.
- Running, then PC held at 0x0042 for 16 cycles with ALLOW_HALT=0 -> fault_out rises on the edge after the 16th stall cycle, fault_cause_out=2, cycle_cnt_out frozen.
- halting_in pulsed in RUN: with ALLOW_HALT=0 -> state 3, cause 1; with ALLOW_HALT=1 -> state 2, fault_out=0. clear_in together with halting_in -> state 0.
- 300 cycles in RUN with CNT_W=8 -> cycle_cnt_out=255 (saturated); then clear_in -> 0.
- reset_n_in pulled low mid-run, between clock edges -> all outputs 0 before the next rising edge.
